data_mem_wbuf: RTL
==================

# data_mem_wbuf

Data-memory responder for the single-cycle ARM core's data port. The core drives the address from ALUResult, the store data from WriteData and the write strobe from MemWrite, and this block returns ReadData. Stores are posted into a small write buffer and drained into a word-addressed RAM when the RAM port is idle. Loads see the youngest buffered store to the same word through forwarding. `stall` goes to the top level so it can hold the PC when the buffer cannot accept a store.

## Interface
- `ADDR_W`, default 6: word-index width; RAM holds 2^ADDR_W 32-bit words.
- `WB_DEPTH`, default 4: write-buffer entries; must be a power of two, at least 2.
- `clk` input 1: clock, rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-high.
- `a` input 32: byte address (ALUResult); word index is `a[ADDR_W+1:2]`; `a[1:0]` and bits above ADDR_W+1 are ignored.
- `wd` input 32: store data (WriteData).
- `we` input 1: store request (MemWrite).
- `re` input 1: load request (driven from the load decode, i.e. MemtoReg).
- `rd` output 32: load data (ReadData).
- `stall` output 1: store not accepted this cycle; top level holds the PC and the instruction.
- `wb_count` output log2(WB_DEPTH)+1: number of occupied buffer entries.
- `wb_empty` output 1: high when `wb_count` is 0.

## Operation
- **RAM:** 2^ADDR_W x 32 register array with asynchronous read and one synchronous write port. Only the drain logic writes it. RAM contents are not reset.
- **Write buffer:** circular FIFO of {index, data} entries, with head pointer, tail pointer and count. No coalescing, so the same index may occupy several entries.
- **Enqueue:** at a posedge with `we=1` and `stall=0`, push {`a[ADDR_W+1:2]`, `wd`} at the tail.
- **Drain:** at a posedge with count>0 and (`re=0` or count=WB_DEPTH), write the head entry into the RAM and pop it.
  - A load suppresses drain unless the buffer is full, so a combined full+store+load cycle cannot deadlock.
- **Simultaneous push and pop:** both occur in the same cycle; count is unchanged.
- **Push when full:** allowed in the same cycle as the forced drain. `stall` is therefore high only when count=WB_DEPTH, `we=1` and no drain this cycle. By the drain rule this never happens, so `stall` is a safety output that is 0 in legal operation.
- **`rd` when `re=1`:** data of the youngest valid entry whose index equals `a[ADDR_W+1:2]`, otherwise `RAM[a[ADDR_W+1:2]]`. The head entry being drained in this cycle still participates in forwarding.
- **`rd` when `re=0`:** forced to 32'h0.
- **Pointer wrap:** head and tail wrap modulo WB_DEPTH. Count saturates neither way; overflow and underflow are prevented by the rules above.
- **Reset:** asserting `reset` at any time, including mid-drain, empties the buffer immediately (count=0, head=tail=0). Pending stores are discarded and the RAM is untouched.

## Timing
- **Reset values:** `wb_count`=0, `wb_empty`=1, `stall`=0. `rd`=0 while `re=0`; with `re=1`, `rd` equals the RAM word, since there is no buffer hit.
- **Load latency:** 0 cycles. `rd` is combinational from `a`, `re` and state, which matches the single-cycle core.
- **Store visibility:** a store accepted at edge N is returned by a load to the same word in the cycle after edge N, via the buffer or via the RAM.
- **RAM update latency:** a store reaches the RAM at the first edge after acceptance with no `re`. In the best case that is the next edge, i.e. 1 cycle.
- **`stall`, `wb_count`, `wb_empty`:** `stall` is combinational. `wb_count` and `wb_empty` are registered state and change only at posedge or at reset.
- **Reset:** asynchronous assertion; deassertion is expected synchronous to `clk`.

## Test plan
- **Reset:** assert `reset` with no prior traffic → `wb_count`=0, `wb_empty`=1, `stall`=0; `rd`=0 with `re=0`.
- **Store then drain:** store 32'hDEADBEEF to address 0x10 with `re=0` on the following cycles → `wb_count`=1 after the first edge and 0 after the next. A load of 0x10 then returns 32'hDEADBEEF from the RAM.
- **Forwarding:** hold `re=1` with loads of other addresses while storing 0x11111111 and then 0x22222222 to 0x20 → `wb_count` reaches 2. A load of 0x20 returns 0x22222222 (youngest) before any drain, and 0x22222222 again after the buffer empties.
- **Full and forced drain:** keep `re=1` and issue 5 consecutive stores to 0x00, 0x04, 0x08, 0x0C and 0x10 → `wb_count` goes 1,2,3,4,4 and `stall` stays 0. The 5th store pushes while the head (0x00) drains. Finally, all five words read back correctly.
- **Wrap-around:** 10 stores interleaved with idle cycles, so head and tail pass index 3→0 twice → every readback matches, and `wb_count` never exceeds 4.
- **Reset mid-operation:** fill 3 entries to 0x30, 0x34 and 0x38, then assert `reset` asynchronously between edges → `wb_count`=0 immediately. Loads of 0x30 to 0x38 return the pre-store RAM contents, since the stores are discarded.

Source files
------------

// File: rtl/data_mem_wbuf.sv
// data_mem_wbuf: word RAM behind a posted write buffer, with store-to-load forwarding
module data_mem_wbuf #(
  parameter int ADDR_W = 6,
  parameter int WB_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  a,
  input  logic [31:0]                  wd,
  input  logic                         we,
  input  logic                         re,
  output logic [31:0]                  rd,
  output logic                         stall,
  output logic [$clog2(WB_DEPTH):0]    wb_count,
  output logic                         wb_empty
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] bidx [WB_DEPTH];
  logic [31:0] bdat [WB_DEPTH];
  logic [PW-1:0] head, tail;
  logic [ADDR_W-1:0] idx;
  logic [31:0] fwd;
  logic full, drain, push;
  logic unused_abits;
  assign unused_abits = ^{a[31:ADDR_W+2], a[1:0]};
  assign idx = a[ADDR_W+1:2];
  assign wb_empty = wb_count == '0;
  assign full = wb_count == CW'(WB_DEPTH);
  // a load holds off draining unless the buffer is full, so a full-buffer store always finds room
  assign drain = !wb_empty && (!re || full);
  assign stall = we && full && !drain;
  assign push = we && !stall;
  // scan oldest to youngest so the youngest matching entry wins; the draining head still counts
  always_comb begin
    fwd = mem[idx];
    for (int i = 0; i < WB_DEPTH; i++)
      if (CW'(i) < wb_count && bidx[head + PW'(i)] == idx) fwd = bdat[head + PW'(i)];
    rd = re ? fwd : 32'h0;
  end
  // buffer pointers and occupancy; reset discards pending stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      wb_count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      wb_count <= wb_count + CW'(push) - CW'(drain);
    end
  end
  // buffer entry storage and the single RAM write port fed from the head entry
  always_ff @(posedge clk) begin
    if (push) begin
      bidx[tail] <= idx;
      bdat[tail] <= wd;
    end
    if (drain) mem[bidx[head]] <= bdat[head];
  end
endmodule
